// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: synchronizes receiver done/error flags, captures bytes into a FWFT FIFO,
// and keeps sticky overflow plus saturating error/drop counters.
module uart_rx_buffer #(
    parameter int NUM_DATA_BITS = 8,
    parameter int DEPTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [NUM_DATA_BITS-1:0]   rx_data,
    input  logic                       rx_done,
    input  logic                       rx_error,
    output logic [NUM_DATA_BITS-1:0]   rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       err_count,
    output logic [CNT_WIDTH-1:0]       drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {WAIT_LOW, WAIT_EDGE, PUSH} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   done_sync, err_sync, settle;
    logic                     done_d, err_d, done_s, err_s, done_rise, err_rise;
    logic                     pop, try_push, wr, drop;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [NUM_DATA_BITS-1:0] mem [DEPTH];
    logic [NUM_DATA_BITS-1:0] rd_hold;

    always_comb begin
        done_s    = done_sync[SYNC_STAGES-1];
        err_s     = err_sync[SYNC_STAGES-1];
        done_rise = done_s && !done_d;
        err_rise  = err_s && !err_d;
        rd_valid  = count != '0;
        full      = count == CW'(DEPTH);
        rd_data   = rd_valid ? mem[rd_ptr] : rd_hold;
        pop       = rd_valid && rd_ready && !clr;
        try_push  = state == PUSH && !clr;
        wr        = try_push && (!full || pop);
        drop      = try_push && !wr;
    end

    // settle keeps WAIT_LOW from trusting the synchronizer until it has refilled after reset,
    // so a done level already high at reset release never looks like a fresh rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_sync  <= '0;
            err_sync   <= '0;
            settle     <= '0;
            done_d     <= 1'b0;
            err_d      <= 1'b0;
            state      <= WAIT_LOW;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            err_count  <= '0;
            drop_count <= '0;
            rd_hold    <= '0;
        end else begin
            done_sync <= {done_sync[SYNC_STAGES-2:0], rx_done};
            err_sync  <= {err_sync[SYNC_STAGES-2:0], rx_error};
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            done_d    <= done_s;
            err_d     <= err_s;
            rd_hold   <= rd_data;
            if (clr) begin
                state      <= WAIT_LOW;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                err_count  <= '0;
                drop_count <= '0;
            end else begin
                state      <= state == WAIT_LOW  ? (settle[SYNC_STAGES-1] && !done_s ? WAIT_EDGE : WAIT_LOW) :
                              state == WAIT_EDGE ? (done_rise ? PUSH : WAIT_EDGE) : WAIT_LOW;
                wr_ptr     <= wr_ptr + AW'(wr);
                rd_ptr     <= rd_ptr + AW'(pop);
                count      <= count + CW'(wr) - CW'(pop);
                overflow   <= overflow | drop;
                err_count  <= err_count + CNT_WIDTH'(err_rise && err_count != '1);
                drop_count <= drop_count + CNT_WIDTH'(drop && drop_count != '1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= rx_data;
    end
endmodule
